png_chunk_packer: RTL

Wraps one PNG chunk around a raw data byte stream: emits the 4-byte length, 4-byte type, the data bytes, then the 4-byte CRC, all MSB first. It sits directly upstream of `crc32`. It feeds `crc32` the type and data bytes with start/valid/last framing, and consumes the CRC it returns to close the chunk. Output goes to the PNG file byte sink.

---
 rtl/png_chunk_packer.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/png_chunk_packer.sv
// png_chunk_packer
// Wraps a raw byte stream in one PNG chunk: 4-byte length, 4-byte type,
// the data bytes, then the 4-byte CRC, all MSB first. The type and data
// bytes are mirrored to an external crc32 block with start/valid/last
// framing, and the CRC it returns is captured and emitted to close the chunk.
//
// Build option:
//   PNG_CHUNK_LEN_CHECK_EN - when defined, a start with len_i[31]=1 is
//   rejected: err_o pulses one cycle later and the block stays idle.
//   When undefined, err_o is tied low and every length is accepted.
module png_chunk_packer (
  input  logic        clk,
  input  logic        rstn,
  // chunk request
  input  logic        start_i,
  input  logic [31:0] len_i,
  input  logic [31:0] typ_i,
  // upstream data bytes
  input  logic        val_i,
  input  logic [7:0]  dat_i,
  output logic        rdy_o,
  // byte sink
  output logic        val_o,
  output logic [7:0]  dat_o,
  output logic        lst_o,
  input  logic        rdy_i,
  // crc32 feed
  output logic        crc_start_o,
  output logic        crc_val_o,
  output logic [7:0]  crc_dat_o,
  output logic        crc_lst_o,
  // crc32 result
  input  logic        crc_val_i,
  input  logic [31:0] crc_dat_i,
  // status
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_TYP,
    ST_DAT,
    ST_WAIT_CRC,
    ST_CRC
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] len_reg, len_next;
  logic [31:0] typ_reg, typ_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [31:0] crc_reg, crc_next;
  logic [1:0]  bidx_reg, bidx_next;
  logic        crc_arm_reg, crc_arm_next;   // crc_lst_o sent, result pending
  logic        crc_cap_reg, crc_cap_next;   // crc_reg holds this chunk's CRC
  logic        done_reg, done_next;
  logic        err_reg, err_next;

  logic [31:0] cnt_inc;
  logic        cap_ok;
  logic        cap_now;
  logic        len_bad;

  // Header/CRC fields split into bytes; index 0 is the most significant byte
  // so the byte index doubles as the transmit order.
  logic [7:0] len_byte [4];
  logic [7:0] typ_byte [4];
  logic [7:0] crc_byte [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bytes
      assign len_byte[gi] = len_reg[31 - 8*gi -: 8];
      assign typ_byte[gi] = typ_reg[31 - 8*gi -: 8];
      assign crc_byte[gi] = crc_reg[31 - 8*gi -: 8];
    end
  endgenerate

`ifdef PNG_CHUNK_LEN_CHECK_EN
  // PNG caps chunk length at 2^31-1, so bit 31 set means an illegal length.
  assign len_bad = len_i[31];
`else
  assign len_bad = 1'b0;
`endif

  assign cnt_inc = cnt_reg + 32'd1;

  // The crc32 result is only taken once the last covered byte has gone out,
  // and only while the chunk is past its header.
  assign cap_ok  = (state_reg == ST_DAT) || (state_reg == ST_WAIT_CRC) ||
                   (state_reg == ST_CRC);
  assign cap_now = cap_ok && crc_arm_reg && !crc_cap_reg && crc_val_i;

  assign busy_o = (state_reg != ST_IDLE);
  assign done_o = done_reg;
  assign err_o  = err_reg;

  // State, counters and latched chunk fields.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= ST_IDLE;
      len_reg     <= 32'd0;
      typ_reg     <= 32'd0;
      cnt_reg     <= 32'd0;
      crc_reg     <= 32'd0;
      bidx_reg    <= 2'd0;
      crc_arm_reg <= 1'b0;
      crc_cap_reg <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      typ_reg     <= typ_next;
      cnt_reg     <= cnt_next;
      crc_reg     <= crc_next;
      bidx_reg    <= bidx_next;
      crc_arm_reg <= crc_arm_next;
      crc_cap_reg <= crc_cap_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  // Next-state logic and all byte-path outputs.
  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    typ_next     = typ_reg;
    cnt_next     = cnt_reg;
    crc_next     = crc_reg;
    bidx_next    = bidx_reg;
    crc_arm_next = crc_arm_reg;
    crc_cap_next = crc_cap_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;
    rdy_o        = 1'b0;
    val_o        = 1'b0;
    dat_o        = 8'h00;
    lst_o        = 1'b0;
    crc_start_o  = 1'b0;
    crc_val_o    = 1'b0;
    crc_dat_o    = 8'h00;
    crc_lst_o    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start_i) begin
          if (len_bad) begin
            err_next = 1'b1;
          end else begin
            crc_start_o  = 1'b1;
            len_next     = len_i;
            typ_next     = typ_i;
            cnt_next     = 32'd0;
            bidx_next    = 2'd0;
            crc_next     = 32'd0;
            crc_arm_next = 1'b0;
            crc_cap_next = 1'b0;
            state_next   = ST_LEN;
          end
        end
      end

      // Length bytes are framing only; crc32 never sees them.
      ST_LEN: begin
        val_o = 1'b1;
        dat_o = len_byte[bidx_reg];
        if (rdy_i) begin
          bidx_next = bidx_reg + 2'd1;
          if (bidx_reg == 2'd3) begin
            state_next = ST_TYP;
          end
        end
      end

      ST_TYP: begin
        val_o = 1'b1;
        dat_o = typ_byte[bidx_reg];
        if (rdy_i) begin
          crc_val_o = 1'b1;
          crc_dat_o = typ_byte[bidx_reg];
          bidx_next = bidx_reg + 2'd1;
          if (bidx_reg == 2'd3) begin
            if (len_reg == 32'd0) begin
              // Empty chunk: the last type byte closes the CRC.
              crc_lst_o  = 1'b1;
              state_next = crc_cap_reg ? ST_CRC : ST_WAIT_CRC;
            end else begin
              state_next = ST_DAT;
            end
          end
        end
      end

      // Zero-latency pass-through between upstream and sink.
      ST_DAT: begin
        val_o = val_i;
        dat_o = dat_i;
        rdy_o = rdy_i;
        if (val_i && rdy_i) begin
          crc_val_o = 1'b1;
          crc_dat_o = dat_i;
          cnt_next  = cnt_inc;
          if (cnt_inc == len_reg) begin
            crc_lst_o  = 1'b1;
            state_next = crc_cap_reg ? ST_CRC : ST_WAIT_CRC;
          end
        end
      end

      ST_WAIT_CRC: begin
        if (crc_cap_reg || cap_now) begin
          state_next = ST_CRC;
        end
      end

      ST_CRC: begin
        val_o = 1'b1;
        dat_o = crc_byte[bidx_reg];
        lst_o = (bidx_reg == 2'd3);
        if (rdy_i) begin
          bidx_next = bidx_reg + 2'd1;
          if (bidx_reg == 2'd3) begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // CRC handshake bookkeeping, shared by every state that closes the feed.
    if (crc_lst_o) begin
      crc_arm_next = 1'b1;
    end
    if (cap_now) begin
      crc_next     = crc_dat_i;
      crc_cap_next = 1'b1;
      crc_arm_next = 1'b0;
    end
  end

endmodule
